predictor_driver: RTL and testbench
===================================

# predictor_driver

Branch-resolution front end for the 2-bit saturating-counter predictor. Accepts resolved branch outcomes from an upstream trace source over a valid/ready handshake, queries the predictor, captures its prediction, then reports the actual outcome back so the predictor can train. Keeps saturating hit/miss statistics for accuracy measurement. Sits between the branch trace source and the predictor, driving all of the predictor's inputs.

## Interface
- `CNT_W`, 16: width of the hit and miss statistic counters.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `outcome_valid`  in  1  upstream has a resolved branch outcome.
- `outcome_taken`  in  1  actual direction of that branch. Valid when `outcome_valid` is high.
- `outcome_ready`  out  1  driver can accept an outcome.
- `request`  out  1  to the predictor: sample-prediction strobe.
- `prediction`  in  1  from the predictor. Registered; valid the cycle after `request`.
- `result`  out  1  to the predictor: train strobe.
- `taken`  out  1  to the predictor: actual direction. Qualified by `result`.
- `stats_clear`  in  1  zero both statistic counters.
- `done`  out  1  one-cycle pulse when a branch completes.
- `last_pred`  out  1  prediction captured for the most recent branch.
- `last_correct`  out  1  most recent prediction matched the outcome.
- `hits`  out  `CNT_W`  number of correct predictions, saturating.
- `misses`  out  `CNT_W`  number of mispredictions, saturating.

## Operation
- FSM states: IDLE, REQ, WAIT, RESOLVE.
- **IDLE**
  - `outcome_ready`=1.
  - On `outcome_valid`: latch `outcome_taken` into `dir_q` and go to REQ.
- **REQ**
  - `request`=1 for exactly one cycle.
  - Next state WAIT.
- **WAIT**
  - `request`=0.
  - At the end of this cycle, sample `prediction` into `pred_q`.
  - Next state RESOLVE.
- **RESOLVE**
  - `result`=1 and `taken`=`dir_q` for exactly one cycle.
  - At the end of this cycle:
    - `done` pulses in the following cycle.
    - `last_pred` is updated to `pred_q`.
    - `last_correct` is updated to (`pred_q`==`dir_q`).
    - `hits` increments if correct; otherwise `misses` increments.
  - Next state IDLE.
- `outcome_ready` is 0 in every state except IDLE. Upstream must hold `outcome_valid` and `outcome_taken` stable until the handshake completes.
- `taken` is driven to 0 whenever `result`=0.
- Counter saturation: at all-ones, an increment leaves the counter unchanged. No wrap-around.
- `stats_clear`:
  - Zeroes `hits` and `misses` on the next edge.
  - If it coincides with a RESOLVE increment, clear wins and the counter ends at 0.
  - Does not disturb the FSM or `last_*`.
- **Reset** (including mid-operation) returns the FSM to IDLE.
  - Reset values: `request`=0, `result`=0, `taken`=0, `done`=0, `last_pred`=0, `last_correct`=0, `hits`=0, `misses`=0, `outcome_ready`=1 (from the cycle after reset deasserts).
  - An aborted branch is neither counted nor trained.
  - Predictor counter state is not reset by the driver.

## Timing
- The handshake completes at edge E0 (IDLE, valid and ready both high).
  - Cycle after E0 (REQ): `request`=1.
  - Next cycle (WAIT): `prediction` is valid and is sampled.
  - Next cycle (RESOLVE): `result`=1.
  - Next cycle: `done`=1, statistics updated, FSM in IDLE with `outcome_ready`=1.
- Throughput: one branch per 4 cycles.
- `outcome_valid` held continuously: the next handshake lands in the same cycle that `done` is high.
- `request` and `result` are never asserted in the same cycle.

## Structure
- Package `predictor_pkg`:
  - state enum `drv_state_t` {IDLE, REQ, WAIT, RESOLVE};
  - default `CNT_W`.
- Sub-module `sat_stat_counter`:
  - parameter width;
  - ports: `inc`, `clr` (clr has priority), `q`;
  - instantiated twice, once for `hits` and once for `misses`.
- All outputs are registered.

## Test plan
- Reset, then apply 4 not-taken outcomes back-to-back to a predictor at its power-up count 11.
  - Required: predictions 1,1,0,0.
  - Required: `hits`=2, `misses`=2, final `last_correct`=1.
- Apply 1 taken outcome with the predictor at 11.
  - Required: `request` in cycle E0+1, `result`=1 and `taken`=1 in cycle E0+3, `done` in cycle E0+4.
  - Required: `hits`=1, `last_pred`=1.
- Assert `rst` during WAIT.
  - Required: next cycle IDLE, all outputs at reset values, no `result` pulse.
  - Required: statistics 0.
- Preload `CNT_W`=4, then run 17 correct predictions.
  - Required: `hits` saturates at 15; `misses`=0.
- Assert `stats_clear` in the same cycle as RESOLVE of a correct branch.
  - Required: `hits`=0 afterward; `done` still pulses; `last_correct`=1.
- Hold `outcome_valid` high for 3 outcomes.
  - Required: `done` pulses exactly 4 cycles apart.
  - Required: `outcome_ready` is low in all non-IDLE cycles.

Source files
------------

// File: rtl/predictor_pkg.sv
// Shared types and defaults for the branch predictor driver.
package predictor_pkg;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResolve
  } drv_state_t;

endpackage

// File: rtl/sat_stat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_stat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/predictor_driver.sv
// Front end that feeds resolved branches to a 2-bit predictor, trains it,
// and keeps saturating hit/miss statistics.
module predictor_driver
  import predictor_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             outcome_valid,
  input  logic             outcome_taken,
  output logic             outcome_ready,
  output logic             request,
  input  logic             prediction,
  output logic             result,
  output logic             taken,
  input  logic             stats_clear,
  output logic             done,
  output logic             last_pred,
  output logic             last_correct,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] misses
);

  drv_state_t state_q, state_d;
  logic dir_q, dir_d;
  logic pred_q;
  logic ready_q, request_q, result_q, taken_q, done_q;
  logic last_pred_q, last_correct_q;
  logic resolve, correct;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (outcome_valid) begin
          state_d = StReq;
          dir_d   = outcome_taken;
        end
      end
      StReq:     state_d = StWait;
      StWait:    state_d = StResolve;
      StResolve: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign resolve = (state_q == StResolve);
  assign correct = (pred_q == dir_q);

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      dir_q          <= 1'b0;
      pred_q         <= 1'b0;
      ready_q        <= 1'b1;
      request_q      <= 1'b0;
      result_q       <= 1'b0;
      taken_q        <= 1'b0;
      done_q         <= 1'b0;
      last_pred_q    <= 1'b0;
      last_correct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ready_q   <= (state_d == StIdle);
      request_q <= (state_d == StReq);
      result_q  <= (state_d == StResolve);
      taken_q   <= (state_d == StResolve) & dir_d;
      done_q    <= resolve;
      if (state_q == StWait) begin
        pred_q <= prediction;
      end
      if (resolve) begin
        last_pred_q    <= pred_q;
        last_correct_q <= correct;
      end
    end
  end

  sat_stat_counter #(
    .Width (CNT_W)
  ) u_hits (
    .clk (clk),
    .rst (rst),
    .inc (resolve & correct),
    .clr (stats_clear),
    .q   (hits)
  );

  sat_stat_counter #(
    .Width (CNT_W)
  ) u_misses (
    .clk (clk),
    .rst (rst),
    .inc (resolve & ~correct),
    .clr (stats_clear),
    .q   (misses)
  );

  assign outcome_ready = ready_q;
  assign request       = request_q;
  assign result        = result_q;
  assign taken         = taken_q;
  assign done          = done_q;
  assign last_pred     = last_pred_q;
  assign last_correct  = last_correct_q;

endmodule

// File: tb/tb_predictor_driver.sv
// Directed bench for predictor_driver with a behavioural 2-bit predictor and
// a scoreboard of expected per-branch results.
module tb_predictor_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // DUT0: default counter width
  logic        ov0 = 1'b0, ot0 = 1'b0, sclr0 = 1'b0;
  logic        ordy0, req0, res0, tk0, done0, lp0, lc0;
  logic        ppred0 = 1'b0;
  logic [15:0] hits0, miss0;

  // DUT1: 4-bit counters for saturation
  logic        ov1 = 1'b0, ot1 = 1'b0, sclr1 = 1'b0;
  logic        ordy1, req1, res1, tk1, done1, lp1, lc1;
  logic        ppred1 = 1'b0;
  logic [3:0]  hits1, miss1;

  predictor_driver #(.CNT_W(16)) u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .outcome_valid (ov0),
    .outcome_taken (ot0),
    .outcome_ready (ordy0),
    .request       (req0),
    .prediction    (ppred0),
    .result        (res0),
    .taken         (tk0),
    .stats_clear   (sclr0),
    .done          (done0),
    .last_pred     (lp0),
    .last_correct  (lc0),
    .hits          (hits0),
    .misses        (miss0)
  );

  predictor_driver #(.CNT_W(4)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .outcome_valid (ov1),
    .outcome_taken (ot1),
    .outcome_ready (ordy1),
    .request       (req1),
    .prediction    (ppred1),
    .result        (res1),
    .taken         (tk1),
    .stats_clear   (sclr1),
    .done          (done1),
    .last_pred     (lp1),
    .last_correct  (lc1),
    .hits          (hits1),
    .misses        (miss1)
  );

  function automatic logic [1:0] upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Behavioural predictors: registered prediction, counters never reset.
  logic [1:0] pcnt0 = 2'b11, pcnt1 = 2'b11;
  logic       pload = 1'b0;

  always @(posedge clk) begin
    if (req0) ppred0 <= pcnt0[1];
    if (pload) pcnt0 <= 2'b11;
    else if (res0) pcnt0 <= upd(pcnt0, tk0);
    if (req1) ppred1 <= pcnt1[1];
    if (res1) pcnt1 <= upd(pcnt1, tk1);
  end

  typedef struct packed {
    logic        pred;
    logic        correct;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;

  exp_t        sbq[$];
  logic [1:0]  sw0 = 2'b11;
  logic [15:0] eh = '0, em = '0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic t, input logic clr);
    exp_t e;
    e.pred    = sw0[1];
    e.correct = (sw0[1] == t);
    if (clr) begin
      eh = '0;
      em = '0;
    end else if (e.correct) begin
      eh = (eh == 16'hffff) ? eh : eh + 16'd1;
    end else begin
      em = (em == 16'hffff) ? em : em + 16'd1;
    end
    e.hits   = eh;
    e.misses = em;
    sbq.push_back(e);
    sw0 = upd(sw0, t);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic send(input logic t, input logic clr);
    for (int i = 0; i < 20 && ordy0 !== 1'b1; i++) @(negedge clk);
    check("send_ready", ordy0, 1);
    push_exp(t, clr);
    ov0 = 1'b1;
    ot0 = t;
    @(negedge clk);
    ov0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sclr0 = clr;
    @(negedge clk);
    sclr0 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("req_res_overlap", {31'b0, req0 & res0}, 0);
      check("taken_unqualified", {31'b0, tk0 & ~res0}, 0);
    end
    if (done0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL sb_empty: observed done=1 required no pending branch");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_last_pred", lp0, e.pred);
        check("sb_last_correct", lc0, e.correct);
        check("sb_hits", hits0, e.hits);
        check("sb_misses", miss0, e.misses);
      end
    end
  end

  initial begin
    int nd;
    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ordy0, 1);
    check("rst_request", req0, 0);
    check("rst_result", res0, 0);
    check("rst_taken", tk0, 0);
    check("rst_done", done0, 0);
    check("rst_last_pred", lp0, 0);
    check("rst_last_correct", lc0, 0);
    check("rst_hits", hits0, 0);
    check("rst_misses", miss0, 0);

    // Four not-taken from power-up count 11: predictions 1,1,0,0
    for (int k = 0; k < 4; k++) send(1'b0, 1'b0);
    @(negedge clk);
    check("t1_hits", hits0, 2);
    check("t1_misses", miss0, 2);
    check("t1_last_correct", lc0, 1);
    check("t1_sb_drained", sbq.size(), 0);

    // Reset stats and restore predictor to 11
    rst = 1'b1;
    pload = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pload = 1'b0;
    sw0 = 2'b11;
    eh = '0;
    em = '0;
    @(negedge clk);

    // Single taken branch, cycle-exact timing
    push_exp(1'b1, 1'b0);
    ov0 = 1'b1;
    ot0 = 1'b1;
    @(negedge clk);
    ov0 = 1'b0;
    check("t2_request_e1", req0, 1);
    check("t2_ready_e1", ordy0, 0);
    @(negedge clk);
    check("t2_request_e2", req0, 0);
    check("t2_result_e2", res0, 0);
    @(negedge clk);
    check("t2_result_e3", res0, 1);
    check("t2_taken_e3", tk0, 1);
    @(negedge clk);
    check("t2_done_e4", done0, 1);
    check("t2_hits", hits0, 1);
    check("t2_last_pred", lp0, 1);

    // Reset during WAIT aborts the branch
    ov0 = 1'b1;
    ot0 = 1'b1;
    @(negedge clk);
    ov0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    eh = '0;
    em = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ordy0, 1);
    check("abort_request", req0, 0);
    check("abort_result", res0, 0);
    check("abort_done", done0, 0);
    check("abort_last_pred", lp0, 0);
    check("abort_last_correct", lc0, 0);
    check("abort_hits", hits0, 0);
    check("abort_misses", miss0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_result", res0, 0);
    end

    // Clear coinciding with RESOLVE of a correct branch
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    @(negedge clk);
    check("clr_hits", hits0, 0);
    check("clr_last_correct", lc0, 1);
    check("clr_sb_drained", sbq.size(), 0);

    // Valid held for three branches: done every 4 cycles
    for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b0);
    ov0 = 1'b1;
    ot0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 9) ov0 = 1'b0;
      check("hold_ready", ordy0, (c % 4 == 0) ? 1 : 0);
      check("hold_done", done0, (c % 4 == 0) ? 1 : 0);
    end
    @(negedge clk);
    check("hold_hits", hits0, 3);
    check("hold_sb_drained", sbq.size(), 0);

    // Saturation on the 4-bit instance: 17 correct taken predictions
    ov1 = 1'b1;
    ot1 = 1'b1;
    nd = 0;
    for (int c = 0; c < 120 && nd < 17; c++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        if (nd == 17) ov1 = 1'b0;
      end
    end
    check("sat_done_count", nd, 17);
    repeat (2) @(negedge clk);
    check("sat_hits", hits1, 15);
    check("sat_misses", miss1, 0);
    check("sat_last_correct", lc1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
